// File: rtl/pr_dma_if.sv
// Peripheral bridge bus as seen by one initiator.
//   master : the DMA side (drives request, address, write enable, write data)
//   slave  : the bridge/arbiter side (drives grant and combinational read data)
// prAddr is a word address (byte address [31:2]). The data and address lines
// are zero while the initiator is not driving, so the bridge can OR initiators.
interface pr_dma_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [29:0] prAddr;
  logic        prWE;
  logic [31:0] prWD;
  logic [31:0] prRD;

  modport master (
    output bus_req, prAddr, prWE, prWD,
    input  bus_gnt, prRD
  );

  modport slave (
    input  bus_req, prAddr, prWE, prWD,
    output bus_gnt, prRD
  );
endinterface

// File: rtl/pr_dma.sv
// Bus-initiator DMA engine: copies len 32-bit words from src to dst, one
// read cycle then one write cycle per word, while holding bridge ownership.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   start          : one-cycle launch pulse (accepted only when idle)
//   abort          : terminate an active transfer (REQ/READ/WRITE)
//   src, dst, len  : word addresses and word count, sampled on accepted start
//   irq_clr        : clears the sticky completion interrupt
//   bus            : bridge bus, master side (request/grant + prAddr/prWE/prWD/prRD)
//   busy           : high in every state except IDLE
//   done           : one-cycle pulse on normal completion
//   irq            : sticky completion interrupt
module pr_dma #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [29:0]      src,
  input  logic [29:0]      dst,
  input  logic [LEN_W-1:0] len,
  input  logic             irq_clr,
  pr_dma_if.master         bus,
  output logic             busy,
  output logic             done,
  output logic             irq
);

  typedef enum logic [2:0] {IDLE, REQ, READ, WRITE, FIN} state_t;

  state_t           state, state_d;
  logic [29:0]      src_q, dst_q;
  logic [LEN_W-1:0] cnt_q;
  logic [31:0]      data_q;
  logic             irq_q;

  logic             req_c, we_c;
  logic [29:0]      addr_c;
  logic [31:0]      wd_c;
  logic             done_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Bus outputs are pure functions of state and grant so that an
  // asynchronous reset drops prWE (and every other line) immediately.
  always_comb begin
    state_d = state;
    req_c   = 1'b0;
    we_c    = 1'b0;
    addr_c  = '0;
    wd_c    = '0;
    done_c  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_d = (len != '0) ? REQ : FIN;
      end
      REQ: begin
        req_c = 1'b1;
        if (abort)             state_d = IDLE;
        else if (bus.bus_gnt)  state_d = READ;
      end
      READ: begin
        req_c = 1'b1;
        if (bus.bus_gnt) addr_c = src_q;
        if (abort)             state_d = IDLE;
        else if (bus.bus_gnt)  state_d = WRITE;
      end
      WRITE: begin
        req_c = 1'b1;
        if (bus.bus_gnt) begin
          addr_c = dst_q;
          we_c   = 1'b1;
          wd_c   = data_q;
        end
        if (abort)                       state_d = IDLE;
        else if (bus.bus_gnt)            state_d = (cnt_q == LEN_W'(1)) ? FIN : READ;
      end
      FIN: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath. A granted WRITE commits even when abort is high in that cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      if (state == IDLE && start && len != '0) begin
        src_q <= src;
        dst_q <= dst;
        cnt_q <= len;
      end
      if (state == READ && bus.bus_gnt) data_q <= bus.prRD;
      if (state == WRITE && bus.bus_gnt) begin
        src_q <= src_q + 30'd1;
        dst_q <= dst_q + 30'd1;
        cnt_q <= cnt_q - LEN_W'(1);
      end
    end
  end

  // Completion set has priority over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              irq_q <= 1'b0;
    else if (state == FIN)   irq_q <= 1'b1;
    else if (irq_clr)        irq_q <= 1'b0;
  end

  assign bus.bus_req = req_c;
  assign bus.prAddr  = addr_c;
  assign bus.prWE    = we_c;
  assign bus.prWD    = wd_c;
  assign busy        = (state != IDLE);
  assign done        = done_c;
  assign irq         = irq_q;

endmodule
